// File: rtl/stage_run_ctrl_if.sv
// Bundle between the front-panel/debug side, the stage sequencer and the
// run/halt controller. The controller uses the slave modport; whatever drives
// the operator requests and the sequencer state uses the master modport.
// When STAGE_RUN_CTRL_CYCLE_CNT_EN is defined, the bundle also carries the
// busy-cycle counter ccount.
interface stage_run_ctrl_if #(
  parameter int CNT_W   = 16,
  parameter int LIMIT_W = 16
);
  // Operator requests
  logic               start;
  logic               stop;
  logic               step;
  logic [LIMIT_W-1:0] limit;
  // Sequencer state taps
  logic               waits;
  logic               execb;
  // Controller outputs
  logic               run;
  logic               halt;
  logic               busy;
  logic [CNT_W-1:0]   icount;
  logic               limit_hit;
`ifdef STAGE_RUN_CTRL_CYCLE_CNT_EN
  logic [CNT_W-1:0]   ccount;

  modport master (
    output start, stop, step, limit, waits, execb,
    input  run, halt, busy, icount, limit_hit, ccount
  );

  modport slave (
    input  start, stop, step, limit, waits, execb,
    output run, halt, busy, icount, limit_hit, ccount
  );
`else
  modport master (
    output start, stop, step, limit, waits, execb,
    input  run, halt, busy, icount, limit_hit
  );

  modport slave (
    input  start, stop, step, limit, waits, execb,
    output run, halt, busy, icount, limit_hit
  );
`endif
endinterface

// File: rtl/stage_run_ctrl.sv
// Run/halt controller for the five-state instruction stage sequencer
// (waits/fetcha/fetchb/execa/execb). Converts start/stop/step requests into
// the sequencer's run pulse and halt level, counts retired instructions and
// auto-halts at a programmable limit (0 = unlimited).
// This block updates on posedge clk; the sequencer updates on negedge, so
// every output here has half a cycle of setup before the sequencer samples it.
// Optional feature macro: STAGE_RUN_CTRL_CYCLE_CNT_EN adds the ccount output,
// a count of busy cycles since the last start.
module stage_run_ctrl #(
  parameter int CNT_W   = 16,
  parameter int LIMIT_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  stage_run_ctrl_if.slave bus
);

  // Width used to compare icount+1 against limit with both zero-extended.
  localparam int CMP_W = (CNT_W > LIMIT_W) ? CNT_W : LIMIT_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t           r_state;
  logic             r_run;
  logic             r_halt;
  logic             r_busy;
  logic [CNT_W-1:0] r_icount;
  logic             r_limit_hit;

  // Previous-cycle request levels for edge detection.
  logic             r_start_q;
  logic             r_stop_q;
  logic             r_step_q;

  logic             w_start_rise;
  logic             w_stop_rise;
  logic             w_step_rise;
  logic [CNT_W-1:0] w_icount_inc;
  logic [CMP_W-1:0] w_inc_ext;
  logic [CMP_W-1:0] w_limit_ext;
  logic             w_limit_en;
  logic             w_limit_match;

  // A held level never retriggers: only a 0->1 change counts as a request.
  assign w_start_rise = bus.start & ~r_start_q;
  assign w_stop_rise  = bus.stop  & ~r_stop_q;
  assign w_step_rise  = bus.step  & ~r_step_q;

  // icount+1 wraps at CNT_W before being widened, so the compare sees the
  // value icount will actually hold after this retire.
  assign w_icount_inc  = r_icount + CNT_W'(1);
  assign w_inc_ext     = CMP_W'(w_icount_inc);
  assign w_limit_ext   = CMP_W'(bus.limit);
  assign w_limit_en    = (bus.limit != '0);
  assign w_limit_match = w_limit_en && bus.execb && (w_inc_ext == w_limit_ext);

  // Request history; sampled every cycle regardless of state so that a level
  // held across a state change cannot look like a fresh edge later.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // in this block sees the pre-edge values of the others.
    if (rst) begin
      r_start_q <= 1'b0;
      r_stop_q  <= 1'b0;
      r_step_q  <= 1'b0;
    end else begin
      r_start_q <= bus.start;
      r_stop_q  <= bus.stop;
      r_step_q  <= bus.step;
    end
  end

  // Controller FSM with registered run/halt/busy/icount/limit_hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_run       <= 1'b0;
      r_halt      <= 1'b0;
      r_busy      <= 1'b0;
      r_icount    <= '0;
      r_limit_hit <= 1'b0;
    end else begin
      // NOTE: run is a one-cycle pulse; defaulting it low here means only the
      // launching branch has to mention it.
      r_run <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_start_rise) begin
            // Free run: fresh instruction count, clear the previous stop cause.
            r_state     <= ST_RUN;
            r_run       <= 1'b1;
            r_halt      <= 1'b0;
            r_busy      <= 1'b1;
            r_icount    <= '0;
            r_limit_hit <= 1'b0;
          end else if (w_step_rise) begin
            // Single step: launch and immediately request halt at execb.
            r_state <= ST_STEP;
            r_run   <= 1'b1;
            r_halt  <= 1'b1;
            r_busy  <= 1'b1;
          end
        end

        ST_RUN: begin
          if (bus.execb) begin
            r_icount <= w_icount_inc;
          end
          // Limit outranks stop so a coincident stop still reports limit_hit.
          if (w_limit_match) begin
            r_state     <= ST_DRAIN;
            r_halt      <= 1'b1;
            r_limit_hit <= 1'b1;
          end else if (w_stop_rise) begin
            r_state <= ST_DRAIN;
            r_halt  <= 1'b1;
          end
        end

        ST_STEP, ST_DRAIN: begin
          // The in-flight instruction finishes; its execb still counts.
          if (bus.execb) begin
            r_icount <= w_icount_inc;
          end
          if (bus.waits) begin
            r_state <= ST_IDLE;
            r_halt  <= 1'b0;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_halt  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.run       = r_run;
  assign bus.halt      = r_halt;
  assign bus.busy      = r_busy;
  assign bus.icount    = r_icount;
  assign bus.limit_hit = r_limit_hit;

`ifdef STAGE_RUN_CTRL_CYCLE_CNT_EN
  logic [CNT_W-1:0] r_ccount;

  // Busy-cycle counter: cleared by an accepted start, +1 per busy posedge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ccount <= '0;
    end else if ((r_state == ST_IDLE) && w_start_rise) begin
      r_ccount <= '0;
    end else if (r_state != ST_IDLE) begin
      r_ccount <= r_ccount + CNT_W'(1);
    end
  end

  assign bus.ccount = r_ccount;
`endif

endmodule
